player_ctrl: RTL and testbench

Game-control stage directly upstream of the maze renderer. It debounces the five push-buttons and runs the welcome/play/win state machine. It moves the player one block per accepted press, rejecting moves into walls using the same `map` and `num` the renderer reads. It drives the renderer's `mode`, `current_x_index` and `current_y_index`.

---
 rtl/player_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_player_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl.sv
// Game control for the maze renderer: debounces the five push-buttons, runs the
// welcome/play/win flow and moves the player one block per accepted press.

module player_db #(
    parameter int DB_LIMIT = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);
    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic        r_level_d;
    logic        r_press;
    logic [19:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == 20'(DB_LIMIT - 1)) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 20'd1;
            end
        end
    end

    assign o_press = r_press;
endmodule

module player_ctrl #(
    parameter int DB_LIMIT = 500000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_start,
    input  logic [4:0]   num,
    input  logic [360:0] map,
    output logic [1:0]   mode,
    output logic [8:0]   current_x_index,
    output logic [8:0]   current_y_index,
    output logic [15:0]  step_count,
    output logic         win_pulse
);
    typedef enum logic [1:0] {S_WELCOME, S_PLAY, S_CHECK, S_WIN} state_t;

    state_t      r_state, w_state_nxt;
    logic [8:0]  r_x, r_y, r_tx, r_ty;
    logic [8:0]  w_x_nxt, w_y_nxt, w_tx_nxt, w_ty_nxt;
    logic [15:0] r_steps, w_steps_nxt;
    logic        r_win, w_win_nxt;
    logic [1:0]  r_mode, w_mode_nxt;

    logic [4:0]  w_btn;
    logic [4:0]  w_press;
    logic        w_p_start;
    logic        w_one_dir;
    logic        w_num_ok;
    logic [8:0]  w_num9;
    logic [8:0]  w_goal;
    logic [8:0]  w_tgt_x, w_tgt_y;
    logic        w_in_range;
    logic [8:0]  w_idx;
    logic        w_wall;

    assign w_btn = {btn_start, btn_right, btn_left, btn_down, btn_up};

    for (genvar g = 0; g < 5; g++) begin : g_db
        player_db #(.DB_LIMIT(DB_LIMIT)) u_db (
            .clk     (clk),
            .rst     (rst),
            .i_btn   (w_btn[g]),
            .o_press (w_press[g])
        );
    end

    assign w_p_start = w_press[4];
    assign w_one_dir = $onehot(w_press[3:0]);
    assign w_num_ok  = (num >= 5'd5) && (num <= 5'd19);
    assign w_num9    = {4'd0, num};
    assign w_goal    = w_num9 - 9'd2;
    // Largest index is 18*19+18 = 360, so 9 bits never wrap for legal num.
    assign w_idx     = r_tx * w_num9 + r_ty;
    assign w_wall    = map[w_idx];

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        w_tgt_x    = r_x;
        w_tgt_y    = r_y;
        w_in_range = 1'b0;
        if (w_press[0]) begin
            w_tgt_y    = r_y - 9'd1;
            w_in_range = (r_y != 9'd0);
        end else if (w_press[1]) begin
            w_tgt_y    = r_y + 9'd1;
            w_in_range = (r_y + 9'd1 < w_num9);
        end else if (w_press[2]) begin
            w_tgt_x    = r_x - 9'd1;
            w_in_range = (r_x != 9'd0);
        end else if (w_press[3]) begin
            w_tgt_x    = r_x + 9'd1;
            w_in_range = (r_x + 9'd1 < w_num9);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_tx_nxt    = r_tx;
        w_ty_nxt    = r_ty;
        w_steps_nxt = r_steps;
        w_win_nxt   = 1'b0;
        unique case (r_state)
            S_WELCOME: begin
                if (w_p_start && w_num_ok) begin
                    w_x_nxt     = 9'd1;
                    w_y_nxt     = 9'd1;
                    w_steps_nxt = '0;
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (w_p_start) begin
                    w_x_nxt     = 9'd1;
                    w_y_nxt     = 9'd1;
                    w_steps_nxt = '0;
                end else if (w_one_dir && w_in_range) begin
                    w_tx_nxt    = w_tgt_x;
                    w_ty_nxt    = w_tgt_y;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_PLAY;
                if (!w_wall) begin
                    w_x_nxt     = r_tx;
                    w_y_nxt     = r_ty;
                    w_steps_nxt = (r_steps == 16'hFFFF) ? r_steps : r_steps + 16'd1;
                    if (r_tx == w_goal && r_ty == w_goal) begin
                        w_win_nxt   = 1'b1;
                        w_state_nxt = S_WIN;
                    end
                end
            end
            S_WIN: begin
                if (w_p_start) w_state_nxt = S_WELCOME;
            end
            default: w_state_nxt = S_WELCOME;
        endcase
    end

    always_comb begin
        unique case (w_state_nxt)
            S_WELCOME: w_mode_nxt = 2'd1;
            S_WIN:     w_mode_nxt = 2'd2;
            default:   w_mode_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_WELCOME;
            r_x     <= 9'd1;
            r_y     <= 9'd1;
            r_tx    <= 9'd1;
            r_ty    <= 9'd1;
            r_steps <= '0;
            r_win   <= 1'b0;
            r_mode  <= 2'd1;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_tx    <= w_tx_nxt;
            r_ty    <= w_ty_nxt;
            r_steps <= w_steps_nxt;
            r_win   <= w_win_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    assign mode            = r_mode;
    assign current_x_index = r_x;
    assign current_y_index = r_y;
    assign step_count      = r_steps;
    assign win_pulse       = r_win;
endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: directed scenarios plus random button traffic, all
// compared every cycle against a game-level model of the debouncer and the maze rules.

module tb_player_ctrl;
    localparam int DB = 4;

    logic         clk;
    logic         rst;
    logic [4:0]   tb_btn;   // [0]=up [1]=down [2]=left [3]=right [4]=start
    logic [4:0]   tb_num;
    logic [360:0] tb_map;
    logic [1:0]   mode;
    logic [8:0]   current_x_index;
    logic [8:0]   current_y_index;
    logic [15:0]  step_count;
    logic         win_pulse;

    player_ctrl #(.DB_LIMIT(DB)) dut (
        .clk             (clk),
        .rst             (rst),
        .btn_up          (tb_btn[0]),
        .btn_down        (tb_btn[1]),
        .btn_left        (tb_btn[2]),
        .btn_right       (tb_btn[3]),
        .btn_start       (tb_btn[4]),
        .num             (tb_num),
        .map             (tb_map),
        .mode            (mode),
        .current_x_index (current_x_index),
        .current_y_index (current_y_index),
        .step_count      (step_count),
        .win_pulse       (win_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_win_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a press is recognised once the button, seen two cycles late,
    // has disagreed with the accepted level for DB consecutive cycles.
    typedef enum {PH_WELCOME, PH_PLAY, PH_CHECK, PH_WIN} ph_t;
    ph_t      m_phase;
    bit       m_valid = 1'b0;
    bit [4:0] m_d1, m_d2, m_lvl, m_lvl_d, m_p;
    int       m_run [5];
    int       m_x, m_y, m_tx, m_ty, m_steps;
    bit       m_win;

    function automatic bit [1:0] phase_mode(input ph_t ph);
        if (ph == PH_WELCOME) return 2'd1;
        if (ph == PH_WIN) return 2'd2;
        return 2'd0;
    endfunction

    task automatic game_step(input bit [4:0] p);
        int n, dirs, tx, ty;
        n    = int'(tb_num);
        dirs = int'(p[0]) + int'(p[1]) + int'(p[2]) + int'(p[3]);
        m_win = 1'b0;
        case (m_phase)
            PH_WELCOME: if (p[4] && n >= 5 && n <= 19) begin
                m_x = 1; m_y = 1; m_steps = 0; m_phase = PH_PLAY;
            end
            PH_PLAY: begin
                if (p[4]) begin
                    m_x = 1; m_y = 1; m_steps = 0;
                end else if (dirs == 1) begin
                    tx = m_x; ty = m_y;
                    if (p[0]) ty = ty - 1;
                    if (p[1]) ty = ty + 1;
                    if (p[2]) tx = tx - 1;
                    if (p[3]) tx = tx + 1;
                    if (tx >= 0 && ty >= 0 && tx < n && ty < n) begin
                        m_tx = tx; m_ty = ty; m_phase = PH_CHECK;
                    end
                end
            end
            PH_CHECK: begin
                m_phase = PH_PLAY;
                if (!tb_map[m_tx * n + m_ty]) begin
                    m_x = m_tx; m_y = m_ty;
                    if (m_steps < 65535) m_steps = m_steps + 1;
                    if (m_x == n - 2 && m_y == n - 2) begin
                        m_win = 1'b1; m_phase = PH_WIN;
                    end
                end
            end
            default: if (p[4]) m_phase = PH_WELCOME;
        endcase
    endtask

    task automatic model_step();
        bit [4:0] new_p;
        bit       seen;
        if (rst) begin
            m_valid = 1'b1;
            m_phase = PH_WELCOME;
            m_x = 1; m_y = 1; m_tx = 1; m_ty = 1; m_steps = 0; m_win = 1'b0;
            m_d1 = '0; m_d2 = '0; m_lvl = '0; m_lvl_d = '0; m_p = '0;
            for (int b = 0; b < 5; b++) m_run[b] = 0;
        end else begin
            game_step(m_p);
            for (int b = 0; b < 5; b++) begin
                seen       = m_d2[b];
                m_d2[b]    = m_d1[b];
                m_d1[b]    = tb_btn[b];
                new_p[b]   = m_lvl[b] & ~m_lvl_d[b];
                m_lvl_d[b] = m_lvl[b];
                if (seen == m_lvl[b]) m_run[b] = 0;
                else begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == DB) begin
                        m_lvl[b] = ~m_lvl[b];
                        m_run[b] = 0;
                    end
                end
            end
            m_p = new_p;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (win_pulse === 1'b1) n_win_seen++;
        if (m_valid)
            check("cycle {mode,x,y,steps,win}",
                  64'({mode, current_x_index, current_y_index, step_count, win_pulse}),
                  64'({phase_mode(m_phase), 9'(m_x), 9'(m_y), 16'(m_steps), m_win}));
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit [4:0] mask, input int hold);
        tb_btn = mask;
        idle(hold);
        tb_btn = '0;
        idle(DB + 8);
    endtask

    task automatic check_pos(input string name, input int x, input int y, input int steps);
        check({name, " x"}, 64'(current_x_index), 64'(x));
        check({name, " y"}, 64'(current_y_index), 64'(y));
        check({name, " steps"}, 64'(step_count), 64'(steps));
    endtask

    task automatic build_test_map();
        tb_num = 5'd5;
        tb_map = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                if (x == 0 || y == 0 || x == 4 || y == 4) tb_map[x * 5 + y] = 1'b1;
        tb_map[11] = 1'b1;
    endtask

    initial begin
        int  reached;
        int  r;
        bit [4:0] mask;
        rst    = 1'b1;
        tb_btn = '0;
        build_test_map();
        idle(3);
        check("reset mode", 64'(mode), 64'd1);
        check("reset win", 64'(win_pulse), 64'd0);
        check_pos("reset", 1, 1, 0);
        rst = 1'b0;
        idle(2);

        // Start: no mode change for DB+3 cycles, then play at (1,1)
        tb_btn[4] = 1'b1;
        for (int i = 0; i < DB + 3; i++) begin
            @(negedge clk);
            check("no early start", 64'(mode), 64'd1);
        end
        @(negedge clk);
        check("start mode", 64'(mode), 64'd0);
        check_pos("start", 1, 1, 0);
        idle(2);
        tb_btn = '0;
        idle(DB + 8);

        // Wall to the right, glitch on up, wall to the left
        press(5'b01000, 10);
        check_pos("wall right", 1, 1, 0);
        check("wall right mode", 64'(mode), 64'd0);
        press(5'b00001, 3);
        check_pos("glitch up", 1, 1, 0);
        press(5'b00100, 10);
        check_pos("wall left", 1, 1, 0);

        // Win path
        n_win_seen = 0;
        press(5'b00010, 10);
        check_pos("down1", 1, 2, 1);
        press(5'b00010, 10);
        check_pos("down2", 1, 3, 2);
        press(5'b01000, 10);
        check_pos("right1", 2, 3, 3);
        press(5'b01000, 10);
        check_pos("right2", 3, 3, 4);
        check("win mode", 64'(mode), 64'd2);
        check("win pulse cycles", 64'(n_win_seen), 64'd1);
        press(5'b00010, 10);
        check_pos("after win", 3, 3, 4);
        check("after win mode", 64'(mode), 64'd2);

        // Restart
        press(5'b10000, 10);
        check("restart welcome", 64'(mode), 64'd1);
        check_pos("restart hold", 3, 3, 4);
        press(5'b10000, 10);
        check("restart play", 64'(mode), 64'd0);
        check_pos("restart", 1, 1, 0);

        // Simultaneous directions are ignored
        press(5'b01001, 10);
        check_pos("up+right", 1, 1, 0);
        press(5'b01010, 10);
        check_pos("down+right", 1, 1, 0);

        // Reset landing in the check cycle discards the pending move
        press(5'b00010, 10);
        check_pos("pre reset move", 1, 2, 1);
        tb_btn[1] = 1'b1;
        reached = 0;
        for (int i = 0; i < 40 && reached == 0; i++) begin
            @(negedge clk);
            if (m_phase == PH_CHECK) reached = 1;
        end
        check("reached check phase", 64'(reached), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst in check mode", 64'(mode), 64'd1);
        check_pos("rst in check", 1, 1, 0);
        rst = 1'b0;
        tb_btn = '0;
        idle(DB + 8);

        // Random traffic, with map/num changes only while on the welcome screen
        for (int it = 0; it < 300; it++) begin
            if (m_phase == PH_WELCOME && $urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 9);
                tb_num = (r == 0) ? 5'(19) : (r == 1) ? 5'(20) : (r == 2) ? 5'(4) : 5'($urandom_range(5, 8));
                for (int i = 0; i < 361; i++) tb_map[i] = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                idle(2);
                rst = 1'b0;
            end
            r = $urandom_range(0, 9);
            if (r < 2) mask = 5'b10000;
            else if (r < 8) mask = 5'(1 << $urandom_range(0, 3));
            else mask = 5'($urandom_range(0, 31));
            tb_btn = mask;
            idle($urandom_range(1, 9));
            tb_btn = '0;
            idle($urandom_range(0, 10));
        end
        idle(DB + 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
